// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate default and receiver state encoding.
package uart_pkg;

    // 100 MHz system clock / 115200 baud; the transmitter uses the same value.
    localparam int DEFAULT_CLK_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock byte FIFO with show-ahead read (head byte always visible).
module sync_fifo #(
    parameter int FIFO_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [7:0]           wdata,
    input  logic                 pop,
    output logic [7:0]           rdata,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_LOG2:0]   count
);

    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CNT_W = FIFO_LOG2 + 1;

    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
    // when a pop frees the head slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            if (do_pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver feeding a show-ahead byte FIFO with sticky error flags.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line high, waiting for a falling edge
// START     | half a bit in, confirm the start bit (else false start)
// DATA      | sample 8 data bits, LSB first, one per bit period
// STOP      | sample the stop bit; 1 = push byte, 0 = framing error
// WAIT_HIGH | after a framing error, hold off until the line returns high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT,
    parameter int FIFO_LOG2   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       ferr,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int            CW      = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TC = CW'(CLK_PER_BIT / 2 - 1);

    logic            rx_meta;
    logic            rx_s;
    rx_state_t       state;
    rx_state_t       state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;
    logic            frame_ok;
    logic            frame_bad;
    logic            push_q;

    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FIFO_LOG2:0] fifo_count;
    logic            fifo_count_unused;
    logic            pop_ok;
    logic            drop;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_s    <= rx_meta;
        end
    end

    // Receiver state, bit timer, bit index, shift register and push strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            push_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            push_q  <= frame_ok;
        end
    end

    // Next-state logic: sample on the terminal count of each timing window.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_TC) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_TC) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_TC) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        frame_ok = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_n   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // The shift register is untouched until the next frame's DATA phase,
    // so it still holds the byte one cycle after the stop sample.
    sync_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .wdata (shreg),
        .pop   (rready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy is only needed by other users of the FIFO.
    assign fifo_count_unused = ^fifo_count;

    assign rvalid = ~fifo_empty;
    assign rdata  = rvalid ? fifo_rdata : 8'h00;
    assign pop_ok = rready & rvalid;
    assign drop   = push_q & fifo_full & ~pop_ok;

    // Sticky error flags; a new event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ferr    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            ferr    <= frame_bad | (ferr & ~err_clr);
            overrun <= drop | (overrun & ~err_clr);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames,
// with a timestamp/queue reference model compared on every cycle.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int FL    = 2;
    localparam int DEPTH = 4;
    // Pin fall to rvalid: 2 sync + 1 detect + half bit + 9 bits + 1 push.
    localparam int LAT   = 2 + 1 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rdata;
    logic       rvalid;
    logic       ferr;
    logic       overrun;

    uart_rx #(.CLK_PER_BIT(CPB), .FIFO_LOG2(FL)) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rready  (rready),
        .ferr    (ferr),
        .overrun (overrun),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int shown  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int         due;
        logic [7:0] b;
    } arr_t;

    arr_t       pend[$];      // bytes scheduled to land in the FIFO at cycle 'due'
    int         ferr_due[$];  // cycles at which a framing error is flagged
    logic [7:0] m_q[$];       // model FIFO contents, head first
    bit         m_ferr = 1'b0;
    bit         m_ovr  = 1'b0;
    int         cyc    = 0;
    bit         cmp_en = 1'b0;
    bit         done   = 1'b0;

    always @(posedge clk) begin : model
        bit popd;
        bit fe;
        bit ov;
        cyc = cyc + 1;
        if (rst) begin
            m_q.delete();
            pend.delete();
            ferr_due.delete();
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            fe = 1'b0;
            ov = 1'b0;
            popd = rready && (m_q.size() > 0);
            if (popd) m_q.delete(0);
            while (pend.size() > 0 && pend[0].due <= cyc) begin
                if (pend[0].due == cyc) begin
                    if (m_q.size() < DEPTH) m_q.push_back(pend[0].b);
                    else ov = 1'b1;
                end
                pend.delete(0);
            end
            while (ferr_due.size() > 0 && ferr_due[0] <= cyc) begin
                if (ferr_due[0] == cyc) fe = 1'b1;
                ferr_due.delete(0);
            end
            m_ferr = fe | (m_ferr & !err_clr);
            m_ovr  = ov | (m_ovr & !err_clr);
        end
    end

    logic       exp_v;
    logic [7:0] exp_d;

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            exp_v = (m_q.size() > 0);
            exp_d = exp_v ? m_q[0] : 8'h00;
            checks++;
            if ({rvalid, rdata, ferr, overrun} !== {exp_v, exp_d, m_ferr, m_ovr}) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL model cyc %0d: got v=%b d=%h fe=%b ov=%b, expected v=%b d=%h fe=%b ov=%b",
                             cyc, rvalid, rdata, ferr, overrun, exp_v, exp_d, m_ferr, m_ovr);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting just after a clock edge. A bad stop bit leaves
    // the line low; the caller decides when it returns high.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        arr_t e;
        if (stop_ok) begin
            e.due = cyc + LAT;
            e.b   = b;
            pend.push_back(e);
        end else begin
            ferr_due.push_back(cyc + LAT - 1);
        end
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_ok;
        tick(CPB);
    endtask

    task automatic pop_expect(input logic [7:0] b, input string name);
        @(negedge clk);
        chk({name, " valid"}, rvalid, 1);
        chk({name, " data"}, rdata, b);
        @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    int t0;
    int lat;
    int due5;
    logic [7:0] rb;
    bit         rok;

    // ---------------- stimulus ----------------
    initial begin
        tick(4);
        @(negedge clk);
        chk("reset rvalid", rvalid, 0);
        chk("reset rdata", rdata, 0);
        chk("reset ferr", ferr, 0);
        chk("reset overrun", overrun, 0);
        tick(1);
        rst = 1'b0;
        cmp_en = 1'b1;
        tick(3);

        // single byte, latency and pop
        fork
            send_byte(8'h55, 1'b1);
            begin
                t0  = cyc;
                lat = -1;
                for (int n = 0; n < 300; n++) begin
                    @(negedge clk);
                    if (rvalid === 1'b1) begin
                        lat = cyc - t0;
                        break;
                    end
                end
                chk("single latency", lat, LAT);
                chk("single rdata", rdata, 8'h55);
            end
        join
        pop_expect(8'h55, "single pop");
        @(negedge clk);
        chk("after pop rvalid", rvalid, 0);
        chk("after pop rdata", rdata, 0);
        tick(1);

        // glitch shorter than half a bit
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(30);
        @(negedge clk);
        chk("glitch rvalid", rvalid, 0);
        chk("glitch ferr", ferr, 0);
        tick(1);

        // framing error followed by a break, then a clean byte
        send_byte(8'hA3, 1'b0);
        tick(3 * CPB - 8);
        @(negedge clk);
        chk("break ferr", ferr, 1);
        chk("break rvalid", rvalid, 0);
        tick(1);
        rxd = 1'b1;
        tick(20);
        @(negedge clk);
        chk("post-break rvalid", rvalid, 0);
        tick(1);
        clr_pulse();
        @(negedge clk);
        chk("ferr cleared", ferr, 0);
        tick(1);
        send_byte(8'h3C, 1'b1);
        pop_expect(8'h3C, "after ferr");

        // overrun: five bytes into four slots
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        for (int i = 1; i <= 4; i++) pop_expect(8'(i), "overrun order");
        @(negedge clk);
        chk("overrun flag", overrun, 1);
        chk("overrun drained", rvalid, 0);
        tick(1);
        clr_pulse();

        // full FIFO with a pop coinciding with the fifth push
        t0   = cyc;
        due5 = t0 + 4 * 10 * CPB + LAT;
        fork
            for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
            begin
                while (cyc < due5 - 1) begin
                    @(posedge clk);
                    #1;
                end
                rready = 1'b1;
                @(posedge clk);
                #1 rready = 1'b0;
            end
        join
        for (int i = 2; i <= 5; i++) pop_expect(8'(i), "full+pop order");
        @(negedge clk);
        chk("full+pop overrun", overrun, 0);
        chk("full+pop drained", rvalid, 0);
        tick(1);

        // reset in the middle of a frame, with a byte queued and ferr set
        send_byte(8'h22, 1'b0);
        rxd = 1'b1;
        tick(CPB);
        send_byte(8'h11, 1'b1);
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rxd = rb[0] | 1'b1;
            rxd = (8'h7E >> i) & 1;
            tick(CPB);
        end
        rxd = 1'b1;
        tick(CPB / 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst rvalid", rvalid, 0);
        chk("rst rdata", rdata, 0);
        chk("rst ferr", ferr, 0);
        chk("rst overrun", overrun, 0);
        tick(1);
        tick(2 * CPB);
        send_byte(8'h81, 1'b1);
        pop_expect(8'h81, "after reset");
        @(negedge clk);
        chk("after reset ferr", ferr, 0);
        tick(1);

        // randomized frames with random pops and clears
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    rb  = 8'($urandom);
                    rok = ($urandom % 6) != 0;
                    send_byte(rb, rok);
                    rxd = 1'b1;
                    if (rok) tick(1 + $urandom % 20);
                    else tick(CPB + $urandom % 20);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rready  = ($urandom % 3) == 0;
                    err_clr = ($urandom % 40) == 0;
                    tick(1);
                end
                rready  = 1'b0;
                err_clr = 1'b0;
            end
        join
        rready = 1'b1;
        tick(10);
        rready = 1'b0;
        tick(2);
        @(negedge clk);
        chk("random drained", rvalid, 0);
        tick(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
